// File: rtl/prog_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_seq_pkg
// Description : Shared constants and helpers for the programmable sequence counter.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_seq_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 8;

  localparam logic [3:0] LEGACY_SEQ [8] = '{
    4'b0000, 4'b0101, 4'b1010, 4'b0110,
    4'b1001, 4'b0011, 4'b1100, 4'b1111
  };

  // Index width; a single-entry table still needs one address bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_seq_if
// Description : Control, table-write and output bundle of prog_seq_counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_seq_if
  import prog_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int AW = idx_w(DEPTH);

  logic             en;
  logic             dir;
  logic             load;
  logic [AW-1:0]    load_idx;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             len_wr;
  logic [AW:0]      len_data;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic [AW-1:0]    idx;
  logic             wrap;

  modport master (
    output en, dir, load, load_idx, wr_en, wr_addr, wr_data, len_wr, len_data,
    input  Q, Qbar, idx, wrap
  );

  modport slave (
    input  en, dir, load, load_idx, wr_en, wr_addr, wr_data, len_wr, len_data,
    output Q, Qbar, idx, wrap
  );

endinterface
`default_nettype wire

// File: rtl/seq_table_ram.sv
`default_nettype none
// ============================================================================
// Module      : seq_table_ram
// Description : Sequence table; sync write, async read, reset to identity codes.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_table_ram
  import prog_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = idx_w(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             we,
  input  wire logic [AW-1:0]    waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic [AW-1:0]    raddr,
  output logic      [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= WIDTH'(i);
      end
    end else if (we && (int'(waddr) < DEPTH)) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/prog_seq_counter.sv
`default_nettype none
// ============================================================================
// Module      : prog_seq_counter
// Description : Programmable-table sequence counter with variable length.
//               Define PROG_SEQ_COUNTER_DIR_EN to enable reverse stepping.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_seq_counter
  import prog_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  wire logic  CLK,
  input  wire logic  CLR,
  prog_seq_if.slave  bus
);

  localparam int AW = idx_w(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]    r_idx;
  logic [LW-1:0]    r_len;
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic [LW-1:0]    w_idx_ext;
  logic [LW-1:0]    w_len_m1;
  logic [AW-1:0]    w_last;
  logic             w_fwd_wrap;
  logic [AW-1:0]    w_fwd_idx;
  logic [AW-1:0]    w_next_idx;
  logic             w_wrap_next;
  logic             w_update;
  logic [WIDTH-1:0] w_rd_data;

  // The read address is the index being moved to, so Q latches that entry
  // before any same-edge write lands in the table.
  seq_table_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk   (CLK),
    .rst   (CLR),
    .we    (bus.wr_en),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (w_next_idx),
    .rdata (w_rd_data)
  );

  assign w_idx_ext  = {1'b0, r_idx};
  assign w_len_m1   = r_len - LW'(1);
  assign w_last     = w_len_m1[AW-1:0];
  assign w_fwd_wrap = (w_idx_ext >= w_len_m1);
  assign w_fwd_idx  = w_fwd_wrap ? '0 : r_idx + AW'(1);

`ifdef PROG_SEQ_COUNTER_DIR_EN
  logic          w_rev_wrap;
  logic [AW-1:0] w_rev_idx;

  assign w_rev_wrap = (r_idx == '0) || (w_idx_ext >= r_len);
  assign w_rev_idx  = w_rev_wrap ? w_last : r_idx - AW'(1);
`endif

  always_comb begin
    w_next_idx  = r_idx;
    w_wrap_next = 1'b0;
    w_update    = 1'b0;
    if (bus.load) begin
      w_update   = 1'b1;
      w_next_idx = ({1'b0, bus.load_idx} >= r_len) ? '0 : bus.load_idx;
    end else if (bus.en) begin
      w_update = 1'b1;
`ifdef PROG_SEQ_COUNTER_DIR_EN
      if (bus.dir) begin
        w_next_idx  = w_rev_idx;
        w_wrap_next = w_rev_wrap;
      end else begin
        w_next_idx  = w_fwd_idx;
        w_wrap_next = w_fwd_wrap;
      end
`else
      w_next_idx  = w_fwd_idx;
      w_wrap_next = w_fwd_wrap;
`endif
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_idx  <= '0;
      r_len  <= LW'(DEPTH);
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      if (w_update) begin
        r_idx <= w_next_idx;
        r_q   <= w_rd_data;
      end
      r_wrap <= w_wrap_next;
      // Out-of-range lengths are dropped; an idx beyond the new length is
      // folded back by the next step's wrap rules.
      if (bus.len_wr && (bus.len_data != '0) && (bus.len_data <= LW'(DEPTH))) begin
        r_len <= bus.len_data;
      end
    end
  end

  assign bus.Q    = r_q;
  assign bus.Qbar = ~r_q;
  assign bus.idx  = r_idx;
  assign bus.wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_prog_seq_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_seq_counter
// Description : Self-checking bench: reference model plus directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_seq_counter;
  import prog_seq_pkg::*;

`ifdef PROG_SEQ_COUNTER_DIR_EN
  localparam bit DIR_ON = 1'b1;
`else
  localparam bit DIR_ON = 1'b0;
`endif

  logic clk;
  logic CLR;
  int   n_checks;
  int   n_fail;

  prog_seq_if #(.WIDTH(4), .DEPTH(8)) bus ();

  prog_seq_counter #(.WIDTH(4), .DEPTH(8)) dut (
    .CLK (clk),
    .CLR (CLR),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int m_table [8];
  int m_len;
  int m_idx;
  int m_q;
  int m_wrap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_table[i] = i;
    m_len  = 8;
    m_idx  = 0;
    m_q    = 0;
    m_wrap = 0;
  endtask

  // Spec-level step rules on plain integers; table write applied after the read.
  task automatic model_update();
    m_wrap = 0;
    if (bus.load) begin
      m_idx = (int'(bus.load_idx) >= m_len) ? 0 : int'(bus.load_idx);
      m_q   = m_table[m_idx];
    end else if (bus.en) begin
      if (DIR_ON && bus.dir) begin
        if (m_idx == 0 || m_idx >= m_len) begin
          m_idx = m_len - 1; m_wrap = 1;
        end else begin
          m_idx = m_idx - 1;
        end
      end else begin
        if (m_idx >= m_len - 1) begin
          m_idx = 0; m_wrap = 1;
        end else begin
          m_idx = m_idx + 1;
        end
      end
      m_q = m_table[m_idx];
    end
    if (bus.wr_en) m_table[bus.wr_addr] = int'(bus.wr_data);
    if (bus.len_wr && bus.len_data >= 1 && bus.len_data <= 8) m_len = int'(bus.len_data);
  endtask

  always @(posedge CLR) model_reset();

  always @(posedge clk) begin
    if (CLR) model_reset();
    else     model_update();
    #1;
    chk("cyc_q",    32'(bus.Q),    32'(m_q));
    chk("cyc_qbar", 32'(bus.Qbar), 32'(~m_q & 15));
    chk("cyc_idx",  32'(bus.idx),  32'(m_idx));
    chk("cyc_wrap", 32'(bus.wrap), 32'(m_wrap));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.en = 1'b0; bus.dir = 1'b0; bus.load = 1'b0; bus.load_idx = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len_wr = 1'b0; bus.len_data = '0;
  endtask

  task automatic do_load(input int i);
    idle(); bus.load = 1'b1; bus.load_idx = 3'(i); tick(); idle();
  endtask

  task automatic do_len(input int l);
    idle(); bus.len_wr = 1'b1; bus.len_data = 4'(l); tick(); idle();
  endtask

  task automatic lit(input string name, input int q, input int i, input int w);
    chk({name, "_q"},    32'(bus.Q),    32'(q));
    chk({name, "_qbar"}, 32'(bus.Qbar), 32'(~q & 15));
    chk({name, "_idx"},  32'(bus.idx),  32'(i));
    chk({name, "_wrap"}, 32'(bus.wrap), 32'(w));
  endtask

  logic [3:0] exp_seq [9];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    CLR      = 1'b1;
    idle();
    #12;
    CLR = 1'b0;
    lit("reset", 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 3'(i); bus.wr_data = LEGACY_SEQ[i];
      tick();
    end
    idle();
    do_load(7);
    lit("load7", 15, 7, 0);
    exp_seq = '{4'h0, 4'h5, 4'hA, 4'h6, 4'h9, 4'h3, 4'hC, 4'hF, 4'h0};
    bus.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      lit($sformatf("legacy%0d", i), int'(exp_seq[i]), i % 8, (i == 0 || i == 8) ? 1 : 0);
    end
    idle();

    do_load(5);
    do_len(3);
    lit("len3_hold", 3, 5, 0);
    bus.en = 1'b1; tick(); idle();
    lit("len3_fold", 0, 0, 1);
    do_len(0);
    do_len(9);
    bus.en = 1'b1;
    tick(); tick();
    lit("len3_step2", 10, 2, 0);
    tick();
    lit("len3_wrap", 0, 0, 1);
    idle();

    do_len(8);
    bus.load = 1'b1; bus.load_idx = 3'd4; bus.en = 1'b1;
    tick(); idle();
    lit("load_over_en", 9, 4, 0);
    do_len(4);
    do_load(6);
    lit("load_beyond_len", 0, 0, 0);

    do_len(1);
    bus.en = 1'b1;
    tick();
    lit("len1_a", 0, 0, 1);
    tick();
    lit("len1_b", 0, 0, 1);
    idle();

    do_len(8);
    do_load(0);
    bus.en = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 4'hF;
    tick(); idle();
    lit("rbw_old", 5, 1, 0);
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    idle();
    lit("rbw_revisit", 15, 1, 0);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 4'hE;
    tick(); idle();
    lit("shown_write", 15, 1, 0);
    do_load(1);
    lit("shown_reload", 14, 1, 0);

    do_load(0);
    bus.en = 1'b1; bus.dir = 1'b1;
`ifdef PROG_SEQ_COUNTER_DIR_EN
    tick();
    lit("rev_wrap", 15, 7, 1);
    tick();
    lit("rev_step", 12, 6, 0);
`else
    tick();
    lit("dir_ignored", 14, 1, 0);
`endif
    idle();

    bus.en = 1'b1;
    tick(); tick();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 4'h7;
    #4;
    CLR = 1'b1;
    #1;
    lit("clr_async", 0, 0, 0);
    tick();
    idle();
    tick();
    CLR = 1'b0;
    bus.en = 1'b1;
    tick();
    lit("post_clr", 1, 1, 0);
    tick();
    lit("post_clr2", 2, 2, 0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
